// File: rtl/audio_pkg.sv
// ============================================================================
// Module      : audio_pkg
// Description : Shared audio sample types, transmitter FSM states and the
//               wire-format helper.
//               Optional macro: I2S_TX_OFFSET_BINARY_EN (offset-binary inputs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package audio_pkg;

    localparam int SAMPLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        sample_t l;
        sample_t r;
    } stereo_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tx_state_t;

    // Converts a producer sample into the two's complement form sent on the wire.
    function automatic sample_t to_wire(input sample_t s);
`ifdef I2S_TX_OFFSET_BINARY_EN
        return sample_t'({~s[SAMPLE_W-1], s[SAMPLE_W-2:0]});
`else
        return s;
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2s_clk_gen.sv
// ============================================================================
// Module      : i2s_clk_gen
// Description : BCLK divider and LRCLK generation; emits the BCLK fall strobe
//               and the frame bit index k.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_clk_gen #(
    parameter int CLK_DIV  = 4,
    parameter int SAMPLE_W = 16,
    parameter int K_W      = $clog2(2 * SAMPLE_W)
) (
    input  logic           clk,
    input  logic           rst_active_high,
    output logic           bclk,
    output logic           lrclk,
    output logic           fall,
    output logic [K_W-1:0] k
);

    localparam int             DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [K_W-1:0] K_LAST   = K_W'(2 * SAMPLE_W - 1);
    localparam logic [K_W-1:0] K_RIGHT  = K_W'(SAMPLE_W);
    localparam logic [K_W-1:0] K_ONE    = K_W'(1);

    logic [DIV_W-1:0] r_div;
    logic             w_wrap;

    assign w_wrap = (r_div == DIV_LAST);
    assign fall   = w_wrap & bclk;

    always_ff @(posedge clk or posedge rst_active_high) begin
        if (rst_active_high) begin
            r_div <= '0;
            bclk  <= 1'b0;
            lrclk <= 1'b1;
            k     <= '0;
        end else begin
            r_div <= w_wrap ? '0 : r_div + DIV_W'(1);
            if (w_wrap) begin
                bclk <= ~bclk;
            end
            // Word select flips one BCLK ahead of the MSB of each slot.
            if (fall) begin
                lrclk <= (k >= K_RIGHT);
                k     <= (k == K_LAST) ? '0 : k + K_ONE;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/i2s_sample_tx.sv
// ============================================================================
// Module      : i2s_sample_tx
// Description : Stereo sample to Philips I2S serializer with one-entry holding
//               buffer and sticky underrun flag.
//               Optional macro: I2S_TX_OFFSET_BINARY_EN (offset-binary inputs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2s_sample_tx
    import audio_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int SAMPLE_W = audio_pkg::SAMPLE_W
) (
    input  logic                clk,
    input  logic                rst_active_high,
    input  logic [SAMPLE_W-1:0] sample_l,
    input  logic [SAMPLE_W-1:0] sample_r,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic                clear_underrun,
    output logic                underrun,
    output logic                i2s_bclk,
    output logic                i2s_lrclk,
    output logic                i2s_sdata
);

    localparam int             K_W    = $clog2(2 * SAMPLE_W);
    localparam logic [K_W-1:0] K_LOAD = K_W'(1);
    localparam logic [K_W-1:0] K_LAST = K_W'(2 * SAMPLE_W - 1);

    logic                  w_fall;
    logic [K_W-1:0]        w_k;
    logic                  w_load;
    logic                  w_accept;
    logic                  w_tx_en;
    logic [K_W-1:0]        w_bit_idx;
    logic [K_W-1:0]        w_bit_pos;
    logic [2*SAMPLE_W-1:0] w_src;

    stereo_t   r_hold;
    stereo_t   r_frame;
    logic      r_hold_full;
    tx_state_t r_state;
    tx_state_t w_state_next;

    i2s_clk_gen #(
        .CLK_DIV  (CLK_DIV),
        .SAMPLE_W (SAMPLE_W),
        .K_W      (K_W)
    ) u_clk_gen (
        .clk             (clk),
        .rst_active_high (rst_active_high),
        .bclk            (i2s_bclk),
        .lrclk           (i2s_lrclk),
        .fall            (w_fall),
        .k               (w_k)
    );

    assign sample_ready = ~r_hold_full;
    assign w_accept     = sample_valid & ~r_hold_full;
    assign w_load       = w_fall && (w_k == K_LOAD);

    // Bit k-1 of the frame goes out at fall k, so k=0 still carries the previous R LSB.
    assign w_bit_idx = (w_k == '0) ? K_LAST : w_k - K_LOAD;
    assign w_bit_pos = K_LAST - w_bit_idx;
    assign w_src     = (w_load && r_hold_full) ? r_hold : r_frame;

    always_ff @(posedge clk or posedge rst_active_high) begin
        if (rst_active_high) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_tx_en      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_tx_en = 1'b1;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_active_high) begin
        if (rst_active_high) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_frame     <= '0;
            i2s_sdata   <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            // Accept and load are exclusive: accept needs empty, load-from-hold needs full.
            if (w_accept) begin
                r_hold      <= '{l: to_wire(sample_l), r: to_wire(sample_r)};
                r_hold_full <= 1'b1;
            end else if (w_load && r_hold_full) begin
                r_hold_full <= 1'b0;
            end

            if (w_load && r_hold_full) begin
                r_frame <= r_hold;
            end

            if (w_load && w_tx_en && !r_hold_full) begin
                underrun <= 1'b1;
            end else if (clear_underrun) begin
                underrun <= 1'b0;
            end

            if (w_fall) begin
                i2s_sdata <= w_tx_en & w_src[w_bit_pos];
            end
        end
    end

endmodule

`default_nettype wire
